// File: rtl/bytelink_pkg.sv
// Shared sizes and FSM state type for the byte-serial link memory responder.
package bytelink_pkg;

  localparam int unsigned BEATS      = 32'd4;
  localparam int unsigned BYTE_W     = 32'd8;
  localparam int unsigned WORD_W     = 32'd32;
  localparam int unsigned BEAT_IDX_W = $clog2(BEATS);

  localparam logic [BEAT_IDX_W-1:0] BEAT_ZERO = {BEAT_IDX_W{1'b0}};
  localparam logic [BEAT_IDX_W-1:0] BEAT_ONE  = BEAT_IDX_W'(1'b1);
  localparam logic [BEAT_IDX_W-1:0] BEAT_LAST = BEAT_IDX_W'(BEATS - 32'd1);

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2,
    RSP      = 2'd3
  } state_t;

endpackage

// File: rtl/bytelink_shreg.sv
// 32-bit byte-lane register: per-beat byte capture, or parallel load then
// byte-wise shift toward bit 0 so the low byte presents the next response beat.
module bytelink_shreg
  import bytelink_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  beat_load,
  input  logic [BEAT_IDX_W-1:0] beat_idx,
  input  logic [BYTE_W-1:0]     beat_byte,
  input  logic                  par_load,
  input  logic [WORD_W-1:0]     par_word,
  input  logic                  shift,
  output logic [WORD_W-1:0]     q
);

  // Word register; parallel load wins over shift, shift over beat capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= {WORD_W{1'b0}};
    end else if (par_load) begin
      q <= par_word;
    end else if (shift) begin
      q <= {{BYTE_W{1'b0}}, q[WORD_W-1:BYTE_W]};
    end else if (beat_load) begin
      for (int unsigned k = 0; k < BEATS; k++) begin
        if (beat_idx == BEAT_IDX_W'(k)) begin
          q[k*BYTE_W +: BYTE_W] <= beat_byte;
        end
      end
    end
  end

endmodule

// File: rtl/bytelink_mem_responder.sv
// Target-side byte-link endpoint: collects a 4-beat command, runs one memory access,
// returns a 4-beat response. Optional partial-frame timeout under BYTELINK_TIMEOUT_EN.
module bytelink_mem_responder
  import bytelink_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 32'd16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] lnk_addr_i,
  input  logic [BYTE_W-1:0] lnk_data_i,
  input  logic              lnk_valid_i,
  input  logic              lnk_we_i,
  output logic [BYTE_W-1:0] lnk_rdata_o,
  output logic              lnk_rvalid_o,
  output logic              lnk_busy_o,
  output logic              frame_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [WORD_W-1:0] mem_addr_o,
  output logic [WORD_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [WORD_W-1:0] mem_rdata_i
);

  state_t                state_r, state_s;
  logic [BEAT_IDX_W-1:0] beat_cnt_r, beat_cnt_s;
  logic [BEAT_IDX_W-1:0] rsp_cnt_r, rsp_cnt_s;
  logic                  we_r, we_s;
  logic                  req_r, req_s;
  logic                  rvalid_r, rvalid_s;
  logic                  busy_r, busy_s;
  logic                  err_r, err_s;
  logic                  cmd_load_s, rsp_load_s, rsp_shift_s, tmo_hit_s;
  logic [WORD_W-1:0]     rsp_word_s, addr_q_s, wdata_q_s, rsp_q_s;
  logic                  unused_rsp_hi_s;

  bytelink_shreg u_addr (
    .clk(clk), .rst(rst), .beat_load(cmd_load_s), .beat_idx(beat_cnt_r), .beat_byte(lnk_addr_i),
    .par_load(1'b0), .par_word({WORD_W{1'b0}}), .shift(1'b0), .q(addr_q_s)
  );

  bytelink_shreg u_wdata (
    .clk(clk), .rst(rst), .beat_load(cmd_load_s), .beat_idx(beat_cnt_r), .beat_byte(lnk_data_i),
    .par_load(1'b0), .par_word({WORD_W{1'b0}}), .shift(1'b0), .q(wdata_q_s)
  );

  bytelink_shreg u_rsp (
    .clk(clk), .rst(rst), .beat_load(1'b0), .beat_idx(BEAT_ZERO), .beat_byte({BYTE_W{1'b0}}),
    .par_load(rsp_load_s), .par_word(rsp_word_s), .shift(rsp_shift_s), .q(rsp_q_s)
  );

`ifdef BYTELINK_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 32'd1);
  logic [TMO_W-1:0] tmo_cnt_r;
  logic             idle_s;

  assign idle_s    = (state_r == COLLECT) && (beat_cnt_r != BEAT_ZERO) && !lnk_valid_i;
  assign tmo_hit_s = idle_s && (tmo_cnt_r == TMO_W'(TIMEOUT_CYC - 32'd1));

  // Idle-gap counter for a partially received frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if (idle_s && !tmo_hit_s) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1'b1);
    end else begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end
  end
`else
  logic unused_tmo_s;
  assign tmo_hit_s    = 1'b0;
  assign unused_tmo_s = (TIMEOUT_CYC == 32'd0);
`endif

  // Next-state, beat bookkeeping and shift-register control.
  always_comb begin
    state_s     = state_r;
    beat_cnt_s  = beat_cnt_r;
    rsp_cnt_s   = rsp_cnt_r;
    we_s        = we_r;
    req_s       = 1'b0;
    rvalid_s    = 1'b0;
    err_s       = lnk_valid_i && (state_r != COLLECT);
    cmd_load_s  = 1'b0;
    rsp_load_s  = 1'b0;
    rsp_shift_s = 1'b0;
    rsp_word_s  = wdata_q_s;
    case (state_r)
      COLLECT: begin
        if (lnk_valid_i) begin
          cmd_load_s = 1'b1;
          if (beat_cnt_r == BEAT_ZERO) begin
            we_s = lnk_we_i;
          end else begin
            we_s = we_r;
          end
          if (beat_cnt_r == BEAT_LAST) begin
            beat_cnt_s = BEAT_ZERO;
            state_s    = MEM_REQ;
            req_s      = 1'b1;
          end else begin
            beat_cnt_s = beat_cnt_r + BEAT_ONE;
          end
        end else if (tmo_hit_s) begin
          beat_cnt_s = BEAT_ZERO;
          err_s      = 1'b1;
        end else begin
          beat_cnt_s = beat_cnt_r;
        end
      end
      MEM_REQ: begin
        if (mem_gnt_i) begin
          if (we_r) begin
            // Writes echo the written word straight back.
            state_s    = RSP;
            rsp_load_s = 1'b1;
            rsp_word_s = wdata_q_s;
            rvalid_s   = 1'b1;
            rsp_cnt_s  = BEAT_ZERO;
          end else begin
            state_s = MEM_WAIT;
          end
        end else begin
          req_s = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_rvalid_i) begin
          state_s    = RSP;
          rsp_load_s = 1'b1;
          rsp_word_s = mem_rdata_i;
          rvalid_s   = 1'b1;
          rsp_cnt_s  = BEAT_ZERO;
        end else begin
          state_s = MEM_WAIT;
        end
      end
      RSP: begin
        rsp_shift_s = 1'b1;
        if (rsp_cnt_r == BEAT_LAST) begin
          state_s = COLLECT;
        end else begin
          rvalid_s  = 1'b1;
          rsp_cnt_s = rsp_cnt_r + BEAT_ONE;
        end
      end
      default: begin
        state_s = COLLECT;
      end
    endcase
    busy_s = (state_s != COLLECT);
  end

  // Control state and registered link/memory strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= COLLECT;
      beat_cnt_r <= BEAT_ZERO;
      rsp_cnt_r  <= BEAT_ZERO;
      we_r       <= 1'b0;
      req_r      <= 1'b0;
      rvalid_r   <= 1'b0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      beat_cnt_r <= beat_cnt_s;
      rsp_cnt_r  <= rsp_cnt_s;
      we_r       <= we_s;
      req_r      <= req_s;
      rvalid_r   <= rvalid_s;
      busy_r     <= busy_s;
      err_r      <= err_s;
    end
  end

  assign unused_rsp_hi_s = ^rsp_q_s[WORD_W-1:BYTE_W];

  assign lnk_rdata_o  = rsp_q_s[BYTE_W-1:0];
  assign lnk_rvalid_o = rvalid_r;
  assign lnk_busy_o   = busy_r;
  assign frame_err_o  = err_r;
  assign mem_req_o    = req_r;
  assign mem_we_o     = we_r;
  assign mem_addr_o   = addr_q_s;
  assign mem_wdata_o  = wdata_q_s;

endmodule
